serial_operand_feeder: RTL and testbench

- Upstream stage of the registered bit-serial half-adder slice.
- Accepts a pair of WIDTH-bit operands through a valid/ready handshake.
- Presents one bit of each operand per beat on its a/b lines, LSB-first, with first/last framing and downstream back-pressure.
- Lets the single-bit adder process full words without any parallel logic.

---
 rtl/serial_add_pkg.sv | 8 +
 rtl/serial_operand_feeder.sv | 91 +++++++++
 tb/tb_serial_operand_feeder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder datapath: feeder FSM states and default operand width.
package serial_add_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} feeder_state_t;

  localparam int SERIAL_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_operand_feeder.sv
// Streams WIDTH-bit operand pairs LSB-first, one bit pair per beat, with first/last framing and back-pressure.
// Optional SERIAL_FEEDER_ZERO_SKIP_EN ends a word once all remaining upper bits of both operands are zero.
module serial_operand_feeder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  feeder_state_t    state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_beat;
  logic             accept;
  logic             consume;

  assign out_valid = (state_q == S_SHIFT);
  assign busy      = out_valid;
  assign a         = sh_a_q[0];
  assign b         = sh_b_q[0];

`ifdef SERIAL_FEEDER_ZERO_SKIP_EN
  assign last_beat = (cnt_q == CNT_LAST) ||
                     ((sh_a_q[WIDTH-1:1] == '0) && (sh_b_q[WIDTH-1:1] == '0));
`else
  assign last_beat = (cnt_q == CNT_LAST);
`endif

  // Framing is qualified by SHIFT so IDLE (cnt==0) never shows a stray first flag.
  assign out_first = out_valid && (cnt_q == '0);
  assign out_last  = out_valid && last_beat;

  // out_ready feeds in_ready directly so the next word loads on the final shift edge.
  assign in_ready  = !out_valid || (out_ready && last_beat);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = S_SHIFT;
      sh_a_d  = op_a;
      sh_b_d  = op_b;
      cnt_d   = '0;
    end else if (consume) begin
      sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
      sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
      if (last_beat) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed self-checking bench for serial_operand_feeder; expectations follow SERIAL_FEEDER_ZERO_SKIP_EN when defined.
module tb_serial_operand_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         a, b, out_valid, out_first, out_last;
  logic         out_ready = 1'b1;
  logic         busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .a(a), .b(b), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  // Index of the final beat for a word, as the framing should report it.
  function automatic int exp_last(input logic [W-1:0] x, input logic [W-1:0] y);
    int l;
    l = W - 1;
`ifdef SERIAL_FEEDER_ZERO_SKIP_EN
    l = 0;
    for (int i = 1; i < W; i++) if (x[i] || y[i]) l = i;
`endif
    return l;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({out_valid, busy, in_ready, out_first, out_last, a, b} !== 7'b0010000) begin
      errs++; $display("FAIL reset_hold v/busy/ird/f/l/a/b=%b exp 0010000",
                       {out_valid, busy, in_ready, out_first, out_last, a, b});
    end
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errs++; $display("FAIL reset_release v/busy/ird=%b exp 001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] ea, eb;
    int last;
    ea = 8'hA5; eb = 8'h3C; last = exp_last(ea, eb);
    @(negedge clk);
    in_valid = 1'b1; op_a = ea; op_b = eb; out_ready = 1'b1;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_accept in_ready=%b exp 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0; op_a = '0; op_b = '0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      vecs++;
      if ({out_valid, a, b, out_first, out_last, in_ready, busy} !==
          {1'b1, ea[i], eb[i], i == 0, i == last, i == last, 1'b1}) begin
        errs++; $display("FAIL stream_beat%0d v/a/b/f/l/ird/busy=%b exp %b", i,
                         {out_valid, a, b, out_first, out_last, in_ready, busy},
                         {1'b1, ea[i], eb[i], i == 0, i == last, i == last, 1'b1});
      end
      @(posedge clk);
    end
    @(negedge clk);
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errs++; $display("FAIL stream_idle v/busy/ird=%b exp 001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] ea, eb;
    int last, k, stall;
    ea = 8'hA5; eb = 8'h3C; last = exp_last(ea, eb); k = 0; stall = 0;
    @(negedge clk);
    in_valid = 1'b1; op_a = ea; op_b = eb; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < last + 4; c++) begin
      out_ready = !(k == 2 && stall < 3);
      @(negedge clk);
      vecs++;
      if ({out_valid, a, b, out_first, out_last, in_ready} !==
          {1'b1, ea[k], eb[k], k == 0, k == last, (k == last) && out_ready}) begin
        errs++; $display("FAIL stall_cyc%0d beat%0d v/a/b/f/l/ird=%b exp %b", c, k,
                         {out_valid, a, b, out_first, out_last, in_ready},
                         {1'b1, ea[k], eb[k], k == 0, k == last, (k == last) && out_ready});
      end
      @(posedge clk);
      if (out_ready) k++; else stall++;
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if ({out_valid, k} !== {1'b0, last + 1}) begin
      errs++; $display("FAIL stall_count valid=%b beats=%0d exp valid=0 beats=%0d", out_valid, k, last + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa [2];
    logic [W-1:0] wb [2];
    logic [W-1:0] ca, cb;
    int w, i;
    wa[0] = 8'hFF; wb[0] = 8'h01; wa[1] = 8'h00; wb[1] = 8'h80;
    @(negedge clk);
    in_valid = 1'b1; op_a = wa[0]; op_b = wb[0]; out_ready = 1'b1;
    @(posedge clk); #1 op_a = wa[1]; op_b = wb[1];
    for (int g = 0; g < 2 * W; g++) begin
      w = g / W; i = g % W; ca = wa[w]; cb = wb[w];
      @(negedge clk);
      vecs++;
      if ({out_valid, a, b, out_first, out_last} !== {1'b1, ca[i], cb[i], i == 0, i == W - 1}) begin
        errs++; $display("FAIL b2b_beat%0d v/a/b/f/l=%b exp %b", g,
                         {out_valid, a, b, out_first, out_last},
                         {1'b1, ca[i], cb[i], i == 0, i == W - 1});
      end
      @(posedge clk);
      #1 if (g == W - 1) in_valid = 1'b0;
    end
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] ea, eb;
    int last;
    ea = 8'hA5; eb = 8'h3C;
    @(negedge clk);
    in_valid = 1'b1; op_a = ea; op_b = eb; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({out_valid, a, b} !== {1'b1, ea[4], eb[4]}) begin
      errs++; $display("FAIL rstmid_beat4 v/a/b=%b exp %b", {out_valid, a, b}, {1'b1, ea[4], eb[4]});
    end
    rst = 1'b1; #1;
    vecs++;
    if ({out_valid, busy, in_ready, out_first, out_last, a, b} !== 7'b0010000) begin
      errs++; $display("FAIL rstmid_async v/busy/ird/f/l/a/b=%b exp 0010000",
                       {out_valid, busy, in_ready, out_first, out_last, a, b});
    end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errs++; $display("FAIL rstmid_release v/ird=%b exp 01", {out_valid, in_ready});
    end
    ea = 8'h01; eb = 8'h01; last = exp_last(ea, eb);
    in_valid = 1'b1; op_a = ea; op_b = eb;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      vecs++;
      if ({out_valid, a, b, out_first, out_last} !== {1'b1, ea[i], eb[i], i == 0, i == last}) begin
        errs++; $display("FAIL rstmid_next%0d v/a/b/f/l=%b exp %b", i,
                         {out_valid, a, b, out_first, out_last}, {1'b1, ea[i], eb[i], i == 0, i == last});
      end
      @(posedge clk);
    end
  endtask

  task automatic test_ignore_mid_word();
    logic [W-1:0] ea, eb, na, nb;
    int last, nlast;
    ea = 8'hA5; eb = 8'h3C; na = 8'h55; nb = 8'hAA;
    last = exp_last(ea, eb); nlast = exp_last(na, nb);
    @(negedge clk);
    in_valid = 1'b1; op_a = ea; op_b = eb; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i <= last; i++) begin
      if (i == 1) begin in_valid = 1'b1; op_a = na; op_b = nb; end
      @(negedge clk);
      vecs++;
      if ({a, b, out_first, out_last, in_ready} !== {ea[i], eb[i], i == 0, i == last, i == last}) begin
        errs++; $display("FAIL ignore_beat%0d a/b/f/l/ird=%b exp %b", i,
                         {a, b, out_first, out_last, in_ready}, {ea[i], eb[i], i == 0, i == last, i == last});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i <= nlast; i++) begin
      @(negedge clk);
      vecs++;
      if ({out_valid, a, b, out_first, out_last} !== {1'b1, na[i], nb[i], i == 0, i == nlast}) begin
        errs++; $display("FAIL ignore_next%0d v/a/b/f/l=%b exp %b", i,
                         {out_valid, a, b, out_first, out_last}, {1'b1, na[i], nb[i], i == 0, i == nlast});
      end
      @(posedge clk);
    end
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL ignore_drain out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_zero_skip();
    logic [W-1:0] za [2];
    logic [W-1:0] zb [2];
    logic [W-1:0] ca, cb;
    int last;
    za[0] = 8'h03; zb[0] = 8'h01; za[1] = 8'h00; zb[1] = 8'h00;
    for (int w = 0; w < 2; w++) begin
      ca = za[w]; cb = zb[w]; last = exp_last(ca, cb);
      @(negedge clk);
      in_valid = 1'b1; op_a = ca; op_b = cb; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i <= last; i++) begin
        @(negedge clk);
        vecs++;
        if ({out_valid, a, b, out_first, out_last} !== {1'b1, ca[i], cb[i], i == 0, i == last}) begin
          errs++; $display("FAIL zskip_w%0d_beat%0d v/a/b/f/l=%b exp %b", w, i,
                           {out_valid, a, b, out_first, out_last}, {1'b1, ca[i], cb[i], i == 0, i == last});
        end
        @(posedge clk);
      end
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b0) begin
        errs++; $display("FAIL zskip_w%0d_end out_valid=%b exp 0 after %0d beats", w, out_valid, last + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_mid_word();
    test_zero_skip();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
